// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus the valid/ready output stream of fifo_burst_reader.
// The master side is the burst reader; the slave side is the FIFO and the consumer.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_data
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pulls a programmed number of words from a FIFO with one-cycle
// read latency and streams them out through a 2-entry skid buffer, then pulses done.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int LEN_BITS   = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [LEN_BITS-1:0] i_burst_len,
    output logic                o_busy,
    output logic                o_done,
    output logic [LEN_BITS-1:0] o_count,
    fifo_burst_reader_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [LEN_BITS-1:0]   r_len_q, r_issued, r_count;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_occ;
    logic                  w_pop, w_credit_ok, w_rd_en, w_accept, w_last;

    assign w_pop = bus.out_valid && bus.out_ready;
    // credit > 0, rearranged as occ + inflight < 2 + pop so it stays unsigned
    assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_rd_en  = !i_reset && (r_state == S_READ) && !bus.fifo_empty
                      && (r_issued < r_len_q) && w_credit_ok;
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = w_pop && ((r_count + LEN_BITS'(1)) == r_len_q);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = (i_burst_len != '0) ? S_READ : S_DONE;
            S_READ:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_len_q    <= '0;
            r_issued   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_occ      <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if (w_accept) begin
                r_count  <= '0;
                r_issued <= '0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_occ    <= '0;
                if (i_burst_len != '0) r_len_q <= i_burst_len;
            end else begin
                if (w_rd_en) r_issued <= r_issued + LEN_BITS'(1);
                // read data lands the cycle after the strobe
                if (r_inflight) begin
                    r_mem[r_wr_ptr] <= bus.fifo_rd_data;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                    r_count  <= r_count + LEN_BITS'(1);
                end
                unique case ({r_inflight, w_pop})
                    2'b10:   r_occ <= r_occ + 2'd1;
                    2'b01:   r_occ <= r_occ - 2'd1;
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_count        = r_count;
    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_valid  = (r_occ != 2'd0);
    assign bus.out_data   = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural depth-8 FIFO and a
// scoreboard queue filled on FIFO writes and drained on output handshakes.
module tb_fifo_burst_reader;
    localparam int DW = 4;
    localparam int LB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LB-1:0] burst_len = '0;
    logic          busy, done;
    logic [LB-1:0] count;
    logic          ready = 1'b0;
    logic          f_clr = 1'b1;
    logic          f_wr = 1'b0;
    logic [DW-1:0] f_wdata = '0;
    logic [DW-1:0] f_rdata = '0;
    logic [DW-1:0] f_mem [8];
    logic [2:0]    f_wp, f_rp;
    logic [3:0]    f_cnt;
    logic          f_rd, f_wr_ok;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_BITS(LB)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_burst_len (burst_len),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty   = (f_cnt == 4'd0);
    assign bus.fifo_rd_data = f_rdata;
    assign bus.out_ready    = ready;
    assign f_rd    = bus.fifo_rd_en && (f_cnt != 4'd0);
    assign f_wr_ok = f_wr && (f_cnt != 4'd8);

    // FIFO model: registered read data, unaffected by the reader's reset
    always @(posedge clk) begin
        if (f_clr) begin
            f_wp  <= '0;
            f_rp  <= '0;
            f_cnt <= '0;
        end else begin
            if (f_rd) begin
                f_rdata <= f_mem[f_rp];
                f_rp    <= f_rp + 3'd1;
            end
            if (f_wr_ok) begin
                f_mem[f_wp] <= f_wdata;
                f_wp        <= f_wp + 3'd1;
            end
            f_cnt <= f_cnt + 4'(f_wr_ok) - 4'(f_rd);
        end
    end

    int nvec = 0, nerr = 0, cyc = 0, scyc = 0;
    int rd_cnt, hs_cnt, done_cnt, nout, first_rd, first_vld, done_cyc;
    logic          prev_stall = 1'b0, done_busy = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; hs_cnt = 0; done_cnt = 0; nout = 0;
        first_rd = -1; first_vld = -1; done_cyc = -1;
    endtask

    // One clock: monitor at the falling edge, then return just after the rising edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset) begin
            chk("rd_en_in_reset", 32'(bus.fifo_rd_en), 0);
            prev_stall = 1'b0;
        end else begin
            if (bus.out_valid && first_vld < 0) first_vld = cyc;
            if (prev_stall) chk("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
            if (bus.out_valid && ready) begin
                hs_cnt++;
                nout--;
                if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
                else chk("out_data", bus.out_data, exp_q.pop_front());
            end
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                nout++;
                if (first_rd < 0) first_rd = cyc;
                chk("rd_while_empty", 32'(bus.fifo_empty), 0);
                chk("outstanding_le2", 32'(nout <= 2), 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            prev_stall = bus.out_valid && !ready;
            prev_data  = bus.out_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            f_wr = 1'b1;
            f_wdata = DW'(i);
            exp_q.push_back(DW'(i));
            tick();
        end
        f_wr = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,0 pattern; 2: starved FIFO fed every other cycle;
    // 3: a second start pulse during READ
    task automatic burst(input int len, input int mode);
        int  wi = 0;
        bit  seen = 0;
        clear_stats();
        start = 1'b1;
        burst_len = LB'(len);
        ready = (mode != 1);
        tick();
        scyc = cyc;
        for (int k = 0; k < 200 && !seen; k++) begin
            start = 1'b0;
            f_wr  = 1'b0;
            ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
            if (mode == 2 && k % 2 == 0 && wi < 4) begin
                f_wr = 1'b1;
                f_wdata = DW'(9 + wi);
                exp_q.push_back(DW'(9 + wi));
                wi++;
            end
            if (mode == 3 && k == 3) begin
                start = 1'b1;
                burst_len = LB'(2);
            end
            tick();
            seen = (done_cnt > 0);
        end
        start = 1'b0;
        f_wr  = 1'b0;
        if (!seen) chk("done_timeout", done_cnt, 1);
        chk("busy_during_done", 32'(done_busy), 1);
        chk("busy_after_done", 32'(busy), 0);
        tick();
        chk("done_single", done_cnt, 1);
    endtask

    initial begin
        clear_stats();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        reset = 1'b0;
        f_clr = 1'b0;

        // basic burst of 8 at full rate
        load(8);
        burst(8, 0);
        chk("basic_first_rd", first_rd, scyc + 1);
        chk("basic_first_valid", first_vld, scyc + 3);
        chk("basic_done_cycle", done_cyc, scyc + 11);
        chk("basic_count", 32'(count), 8);
        chk("basic_rd_pulses", rd_cnt, 8);
        chk("basic_sb_empty", exp_q.size(), 0);

        // backpressure
        load(8);
        burst(8, 1);
        chk("bp_count", 32'(count), 8);
        chk("bp_rd_pulses", rd_cnt, 8);
        chk("bp_handshakes", hs_cnt, 8);
        chk("bp_sb_empty", exp_q.size(), 0);

        // starved FIFO
        burst(4, 2);
        chk("starve_count", 32'(count), 4);
        chk("starve_rd_pulses", rd_cnt, 4);
        chk("starve_sb_empty", exp_q.size(), 0);

        // partial then zero length
        load(8);
        burst(3, 0);
        chk("partial_count", 32'(count), 3);
        chk("partial_rd_pulses", rd_cnt, 3);
        chk("partial_fifo_left", 32'(f_cnt), 5);
        chk("partial_fifo_front", 32'(f_mem[f_rp]), 3);
        chk("partial_sb_left", exp_q.size(), 5);
        burst(0, 0);
        chk("zero_done_cycle", done_cyc, scyc + 1);
        chk("zero_rd_pulses", rd_cnt, 0);
        chk("zero_fifo_left", 32'(f_cnt), 5);
        f_clr = 1'b1;
        tick();
        f_clr = 1'b0;
        exp_q.delete();

        // reset after 3 of 8 words
        load(8);
        clear_stats();
        start = 1'b1;
        burst_len = LB'(8);
        ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && hs_cnt < 3; k++) tick();
        chk("mid_hs3", hs_cnt, 3);
        reset = 1'b1;
        ready = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 0);
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_done", 32'(done), 0);
        reset = 1'b0;
        f_clr = 1'b1;
        tick();
        f_clr = 1'b0;
        exp_q.delete();

        // second start while busy is ignored
        load(8);
        burst(5, 3);
        chk("busy_start_count", 32'(count), 5);
        chk("busy_start_rd_pulses", rd_cnt, 5);
        chk("busy_start_sb_left", exp_q.size(), 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
